// File: rtl/mod_div_unit_if.sv
// +------------------------------------------------------------------+
// | mod_div_unit_if : operand/result bundle for mod_div_unit  rev 1.0 |
// +------------------------------------------------------------------+
`default_nettype none

interface mod_div_unit_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] remainder;
  logic [WIDTH-1:0] quotient;
  logic             div_by_zero;
  logic [2:0]       state;

  modport master (
    output start, dividend, divisor,
    input  busy, done, remainder, quotient, div_by_zero, state
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, remainder, quotient, div_by_zero, state
  );
endinterface

`default_nettype wire

// File: rtl/mod_div_unit.sv
// +------------------------------------------------------------------+
// | mod_div_unit : unsigned divider by repeated subtraction  rev 1.0  |
// +------------------------------------------------------------------+
`default_nettype none

module mod_div_unit #(
  parameter int WIDTH = 8
) (
  input  wire logic     clk,
  input  wire logic     reset,
  mod_div_unit_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'b000,
    S_CHECK = 3'b001,
    S_COMP  = 3'b011,
    S_SUB   = 3'b010,
    S_DONE  = 3'b100
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic             dbz_q, dbz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    q_d     = q_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dbz_d   = dbz_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d     = bus.dividend;
          b_d     = bus.divisor;
          q_d     = '0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (b_q == '0) begin
          rem_d   = a_q;
          quo_d   = '1;
          dbz_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_COMP;
        end
      end
      S_COMP: begin
        if (a_q < b_q) begin
          rem_d   = a_q;
          quo_d   = q_q;
          dbz_d   = 1'b0;
          state_d = S_DONE;
        end else begin
          state_d = S_SUB;
        end
      end
      S_SUB: begin
        // A >= B is guaranteed here, so neither operation can wrap
        a_d     = a_q - b_q;
        q_d     = q_q + {{(WIDTH-1){1'b0}}, 1'b1};
        state_d = S_COMP;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Status flags are registered from the next state so they align with it
    done_d = (state_d == S_DONE);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      q_q     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      q_q     <= q_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.remainder   = rem_q;
  assign bus.quotient    = quo_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.state       = state_q;

endmodule

`default_nettype wire

// File: doc/mod_div_unit.md
MOD_DIV_UNIT -- requirements
Module: mod_div_unit

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result bit width (legal range 2..32).
REQ-002 The block SHALL use one clock; reset is synchronous and active-low.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  synchronous active-low reset (0 = reset).
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 dividend  input  WIDTH  unsigned dividend, captured on accepted start.
REQ-007 divisor  input  WIDTH  unsigned divisor, captured on accepted start.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 done  output  1  one-cycle pulse, high only in DONE.
REQ-010 remainder  output  WIDTH  registered remainder.
REQ-011 quotient  output  WIDTH  registered quotient.
REQ-012 div_by_zero  output  1  registered flag, high when last operation had divisor 0.
REQ-013 state  output  3  current FSM encoding, for debug.

Function
REQ-014 FSM states and encodings: IDLE=000, CHECK=001, COMP=011, SUB=010, DONE=100; unused codes SHALL go to IDLE next cycle.
REQ-015 IDLE, start=1: capture A<=dividend, B<=divisor, Q<=0; next state CHECK. IDLE, start=0: stay in IDLE.
REQ-016 CHECK: B==0 -> DONE and load div_by_zero=1, remainder=A, quotient=all ones. Otherwise -> COMP.
REQ-017 COMP: A<B (unsigned) -> DONE and load remainder=A, quotient=Q, div_by_zero=0. Otherwise -> SUB.
REQ-018 SUB: A<=A-B and Q<=Q+1, both WIDTH bits; next state COMP; no underflow or overflow is possible.
REQ-019 DONE: done=1 for exactly one cycle; next state IDLE, unconditionally.
REQ-020 Latency: start accepted at cycle T gives done at T+3+2*q, where q=floor(dividend/divisor). Divisor 0 gives done at T+2.
REQ-021 start while busy SHALL be ignored; the captured operands SHALL NOT change.
REQ-022 start high in the DONE cycle SHALL be ignored; it is accepted only if still high in the following IDLE cycle.
REQ-023 remainder, quotient and div_by_zero SHALL hold their values from DONE until the next DONE; they SHALL NOT change during computation.
REQ-024 Input operand changes after capture SHALL have no effect on the result.
REQ-025 Worst-case latency, dividend=2^WIDTH-1 and divisor=1: 3+2*(2^WIDTH-1) cycles.

Reset
REQ-026 reset=0 at a rising edge SHALL force state=IDLE and set busy, done, remainder, quotient, div_by_zero and the internal A, B, Q to 0.
REQ-027 Reset mid-operation SHALL abort the operation with no done pulse; normal operation resumes on the first edge with reset=1.
REQ-028 reset has priority over start in the same cycle.

Verification (WIDTH=8)
REQ-029 dividend=17, divisor=5, start at T -> done at T+9, remainder=2, quotient=3, div_by_zero=0.
REQ-030 dividend=3, divisor=7 -> done at T+3, remainder=3, quotient=0.
REQ-031 dividend=42, divisor=0 -> done at T+2, div_by_zero=1, remainder=42, quotient=255.
REQ-032 dividend=255, divisor=1 -> done at T+513, quotient=255, remainder=0; busy high from T+1 to T+513.
REQ-033 Start 20/6, then pulse start with 9/2 at T+4 -> the second start is ignored; done at T+9, remainder=2, quotient=3.
REQ-034 Start 100/3, assert reset=0 at T+10 -> state=000 and all outputs 0 next cycle, no done pulse; a following start of 7/7 gives remainder=0, quotient=1.
